// File: rtl/regfile_param.sv
// ----------------------------------------------------------------------------
// regfile_param
//   Parametrised register file for the decode stage. Multiple independent
//   combinational read ports, one synchronous write port, optional same-cycle
//   write-to-read bypass, and a hard-wired zero register. A built-in
//   sequencer loads rf[i] = i after reset, or on request while running.
//
// Ports
//   clk       clock, all state updates on posedge
//   reset_n   asynchronous active-low reset (state=INIT, idx=0, ready=0)
//   we        write enable (honoured only while ready)
//   wa        write address
//   wd        write data
//   ra        packed read addresses, port k = ra[k*AW +: AW]
//   rd        packed read data,      port k = rd[k*N  +: N]
//   init_req  request re-initialisation (sampled only while running)
//   ready     registered, 1 while the file is in normal operation
// ----------------------------------------------------------------------------
module regfile_param #(
    parameter int N        = 64,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            we,
    input  logic [$clog2(NREG)-1:0]         wa,
    input  logic [N-1:0]                    wd,
    input  logic [NRD*$clog2(NREG)-1:0]     ra,
    output logic [NRD*N-1:0]                rd,
    input  logic                            init_req,
    output logic                            ready
);

    localparam int AW = $clog2(NREG);

    // idx is one bit wider than an address so NREG itself is representable
    localparam logic [AW:0]   NREG_L   = (AW+1)'(NREG);
    localparam logic [AW:0]   LAST_IDX = (AW+1)'(NREG - 1);
    localparam logic [AW-1:0] ZERO_L   = AW'(ZERO_REG);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW:0]     idx_q, idx_d;
    logic            ready_q, ready_d;
    logic [N-1:0]    rf_q [NREG];

    logic            rf_we_s;
    logic [AW-1:0]   rf_wa_s;
    logic [N-1:0]    rf_wd_s;
    logic [NRD*N-1:0] rd_s;

    // Next-state, sequencer index and the single shared array write port
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rf_we_s = 1'b0;
        rf_wa_s = wa;
        rf_wd_s = wd;
        case (state_q)
            ST_INIT: begin
                // Sequencer owns the write port; external we is ignored here
                rf_we_s = reset_n;
                rf_wa_s = idx_q[AW-1:0];
                if (idx_q[AW-1:0] == ZERO_L) begin
                    rf_wd_s = '0;
                end else begin
                    rf_wd_s = N'(idx_q);
                end
                idx_d = idx_q + (AW+1)'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    // Re-initialisation wins over a write in the same cycle
                    state_d = ST_INIT;
                    idx_d   = '0;
                end else if (we && (wa != ZERO_L) && ({1'b0, wa} < NREG_L)) begin
                    rf_we_s = reset_n;
                end else begin
                    rf_we_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    // Register array: contents are not reset, the sequencer loads them
    always_ff @(posedge clk) begin
        if (rf_we_s) begin
            rf_q[rf_wa_s] <= rf_wd_s;
        end
    end

    // Combinational read ports, each decoded independently
    always_comb begin
        rd_s = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!ready_q) begin
                rd_s[k*N +: N] = '0;
            end else if ((ra[k*AW +: AW] == ZERO_L) ||
                         ({1'b0, ra[k*AW +: AW]} >= NREG_L)) begin
                rd_s[k*N +: N] = '0;
            end else if ((BYPASS != 0) && we && (wa == ra[k*AW +: AW])) begin
                rd_s[k*N +: N] = wd;
            end else begin
                rd_s[k*N +: N] = rf_q[ra[k*AW +: AW]];
            end
        end
    end

    assign rd    = rd_s;
    assign ready = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// ----------------------------------------------------------------------------
// tb_regfile_param
//   Three instances share one stimulus stream: default (bypass, 2 ports),
//   no-bypass (2 ports) and bypass with 3 read ports. Directed scenarios are
//   followed by a randomized phase checked against a behavioural model of
//   the register contents and the init countdown.
// ----------------------------------------------------------------------------
module tb_regfile_param;

    localparam int N    = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int ZR   = 31;

    logic              clk;
    logic              reset_n;
    logic              we;
    logic [AW-1:0]     wa;
    logic [N-1:0]      wd;
    logic [2*AW-1:0]   ra;
    logic [3*AW-1:0]   ra3;
    logic [2*N-1:0]    rd;
    logic [2*N-1:0]    rd_nb;
    logic [3*N-1:0]    rd3;
    logic              init_req;
    logic              ready;
    logic              ready_nb;
    logic              ready3;

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    logic [N-1:0] model [NREG];
    int           init_left;
    logic         ready_m;

    regfile_param #(.N(N), .NREG(NREG), .NRD(2), .ZERO_REG(ZR), .BYPASS(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd), .init_req(init_req), .ready(ready));

    regfile_param #(.N(N), .NREG(NREG), .NRD(2), .ZERO_REG(ZR), .BYPASS(0)) u_nb (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_nb), .init_req(init_req), .ready(ready_nb));

    regfile_param #(.N(N), .NREG(NREG), .NRD(3), .ZERO_REG(ZR), .BYPASS(1)) u_p3 (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra3),
        .rd(rd3), .init_req(init_req), .ready(ready3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_model();
        for (int i = 0; i < NREG; i++) begin
            model[i] = (i == ZR) ? 64'd0 : 64'(i);
        end
    endtask

    task automatic set_reset(input logic v);
        reset_n = v;
        if (!v) begin
            ready_m   = 1'b0;
            init_left = NREG;
            fill_model();
        end
    endtask

    // Expected read value for one port, straight from the read rules
    function automatic logic [N-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (!ready_m)                    return 64'd0;
        if (a == 5'(ZR))                 return 64'd0;
        if (byp && we && (wa == a))      return wd;
        return model[a];
    endfunction

    // Advance one clock: model follows the posedge, then return at negedge
    task automatic cycle();
        @(posedge clk);
        if (!reset_n) begin
            init_left = NREG;
            ready_m   = 1'b0;
        end else if (init_left > 0) begin
            init_left--;
            ready_m = (init_left == 0);
        end else if (init_req) begin
            init_left = NREG;
            ready_m   = 1'b0;
            fill_model();
        end else if (we && (wa != 5'(ZR))) begin
            model[wa] = wd;
        end
        @(negedge clk);
    endtask

    initial begin
        we = 1'b0; wa = '0; wd = '0; ra = '0; ra3 = '0; init_req = 1'b0;
        set_reset(1'b0);

        // 1: reset, init countdown, initial contents
        repeat (3) cycle();
        set_reset(1'b1);
        for (int i = 0; i < NREG; i++) begin
            #1;
            if (ready !== 1'b0 || rd[N-1:0] !== 64'd0) begin
                check("init_ready_low", {63'd0, ready}, 64'd0);
                check("init_rd_zero", rd[N-1:0], 64'd0);
            end
            cycle();
        end
        ra = {5'd31, 5'd5};
        #1;
        check("ready_after_init", {63'd0, ready}, 64'd1);
        check("init_x5", rd[N-1:0], 64'd5);
        check("init_x31", rd[2*N-1:N], 64'd0);
        ra = {5'd31, 5'd30};
        #1;
        check("init_x30", rd[N-1:0], 64'd30);

        // 2: same-cycle bypass vs. no bypass, then committed value
        we = 1'b1; wa = 5'd3; wd = 64'hDEAD; ra = {5'd0, 5'd3};
        #1;
        check("bypass_rd0", rd[N-1:0], 64'hDEAD);
        check("nobypass_rd0", rd_nb[N-1:0], 64'd3);
        cycle();
        we = 1'b0;
        #1;
        check("after_write_byp", rd[N-1:0], 64'hDEAD);
        check("after_write_nb", rd_nb[N-1:0], 64'hDEAD);

        // 3: zero register ignores writes
        we = 1'b1; wa = 5'd31; wd = 64'hFFFF; ra = {5'd3, 5'd31};
        #1;
        check("zero_during", rd[N-1:0], 64'd0);
        cycle();
        we = 1'b0;
        #1;
        check("zero_after", rd[N-1:0], 64'd0);
        check("zero_other_unchanged", rd[2*N-1:N], 64'hDEAD);

        // 4: init_req wins over a same-cycle write
        we = 1'b1; wa = 5'd3; wd = 64'd7;
        cycle();
        we = 1'b1; wa = 5'd4; wd = 64'd9; init_req = 1'b1;
        cycle();
        we = 1'b0; init_req = 1'b0;
        #1;
        check("reinit_ready_low", {63'd0, ready}, 64'd0);
        repeat (NREG - 1) cycle();
        #1;
        check("reinit_still_low", {63'd0, ready}, 64'd0);
        cycle();
        ra = {5'd4, 5'd3};
        #1;
        check("reinit_ready_high", {63'd0, ready}, 64'd1);
        check("reinit_x3", rd[N-1:0], 64'd3);
        check("reinit_x4", rd[2*N-1:N], 64'd4);

        // 5: reset mid-INIT restarts the sequence; we during INIT ignored
        set_reset(1'b0);
        cycle();
        set_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            we = i[0]; wa = 5'd7; wd = 64'd123;
            cycle();
        end
        set_reset(1'b0);
        repeat (2) cycle();
        set_reset(1'b1);
        for (int i = 0; i < NREG; i++) begin
            we = i[0]; wa = 5'd7; wd = 64'd123;
            #1;
            if (ready !== 1'b0) check("restart_ready_low", {63'd0, ready}, 64'd0);
            cycle();
        end
        we = 1'b0; ra = {5'd0, 5'd7};
        #1;
        check("restart_ready_high", {63'd0, ready}, 64'd1);
        check("restart_x7", rd[N-1:0], 64'd7);

        // 6: three read ports hitting the same address with bypass
        we = 1'b1; wa = 5'd2; wd = 64'd5; ra3 = {5'd31, 5'd2, 5'd2};
        #1;
        check("p3_rd0", rd3[N-1:0], 64'd5);
        check("p3_rd1", rd3[2*N-1:N], 64'd5);
        check("p3_rd2", rd3[3*N-1:2*N], 64'd0);
        cycle();
        we = 1'b0;

        // Randomized phase against the model
        for (int t = 0; t < 400; t++) begin
            we       = 1'($urandom_range(0, 1));
            wa       = 5'($urandom_range(0, 31));
            wd       = {32'($urandom), 32'($urandom)};
            ra       = 10'($urandom);
            ra3      = 15'($urandom);
            init_req = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) ra[AW-1:0] = wa;
            if ($urandom_range(0, 3) == 0) ra3[2*AW-1:AW] = wa;
            #1;
            check("rnd_ready", {63'd0, ready}, {63'd0, ready_m});
            for (int k = 0; k < 2; k++) begin
                check("rnd_byp", rd[k*N +: N], exp_rd(ra[k*AW +: AW], 1'b1));
                check("rnd_nb", rd_nb[k*N +: N], exp_rd(ra[k*AW +: AW], 1'b0));
            end
            for (int k = 0; k < 3; k++) begin
                check("rnd_p3", rd3[k*N +: N], exp_rd(ra3[k*AW +: AW], 1'b1));
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
